// File: rtl/fg_trapezoid_gen_pkg.sv
// Shared types and constants for the trapezoid/pulse waveform generator.
// Contents: FSM state encoding (Idle=0, Rise=1, On=2, Fall=3, Low=4) and its width.
package fg_trapezoid_gen_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StIdle = 3'd0,
    StRise = 3'd1,
    StOn   = 3'd2,
    StFall = 3'd3,
    StLow  = 3'd4
  } fg_state_e;

endpackage

// File: rtl/fg_trapezoid_gen_if.sv
// Settings/output bundle between the register file (master) and fg_trapezoid_gen (slave).
// Signals: clk_en_i sample strobe, en_i run enable, period_i/on_time_i timing,
//   k_rise_i/k_fall_i slopes, amplitude_i plateau level, invert_i (only with FG_TRAP_INVERT_EN),
//   out_o signed waveform, state_o FSM state, period_start_o first active cycle of a period.
interface fg_trapezoid_gen_if #(
  parameter int unsigned COUNTER_BITWIDTH  = 32,
  parameter int unsigned WAVEFORM_BITWIDTH = 16
);
  import fg_trapezoid_gen_pkg::*;

  logic                           clk_en_i;
  logic                           en_i;
  logic [COUNTER_BITWIDTH-1:0]    period_i;
  logic [COUNTER_BITWIDTH-1:0]    on_time_i;
  logic [WAVEFORM_BITWIDTH-1:0]   k_rise_i;
  logic [WAVEFORM_BITWIDTH-1:0]   k_fall_i;
  logic [WAVEFORM_BITWIDTH-1:0]   amplitude_i;
`ifdef FG_TRAP_INVERT_EN
  logic                           invert_i;
`endif
  logic signed [WAVEFORM_BITWIDTH:0] out_o;
  logic [StateWidth-1:0]          state_o;
  logic                           period_start_o;

  modport master (
`ifdef FG_TRAP_INVERT_EN
    output invert_i,
`endif
    output clk_en_i, en_i, period_i, on_time_i, k_rise_i, k_fall_i, amplitude_i,
    input  out_o, state_o, period_start_o
  );

  modport slave (
`ifdef FG_TRAP_INVERT_EN
    input  invert_i,
`endif
    input  clk_en_i, en_i, period_i, on_time_i, k_rise_i, k_fall_i, amplitude_i,
    output out_o, state_o, period_start_o
  );

endinterface

// File: rtl/fg_trapezoid_gen_sat_step.sv
// Saturating step unit: one shared adder performs either val+step clamped at limit, or
// val-step clamped at 0.
// Ports: i_val current value, i_step increment/decrement, i_limit upper clamp, i_sub select
//   subtract, o_res clamped result, o_reached high when the clamp (limit or 0) is hit.
module fg_trapezoid_gen_sat_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_res,
  output logic             o_reached
);

  logic [WIDTH:0] w_opb;
  logic [WIDTH:0] w_sum;

  // Subtract as val + ~step + 1; both operands are < 2^WIDTH so bit WIDTH is the sign.
  assign w_opb = i_sub ? ~{1'b0, i_step} : {1'b0, i_step};
  assign w_sum = {1'b0, i_val} + w_opb + {{WIDTH{1'b0}}, i_sub};

  always_comb begin
    if (i_sub) begin
      o_reached = w_sum[WIDTH] || (w_sum == '0);
      o_res     = o_reached ? '0 : w_sum[WIDTH-1:0];
    end else begin
      o_reached = (w_sum >= {1'b0, i_limit});
      o_res     = o_reached ? i_limit : w_sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fg_trapezoid_gen.sv
// Trapezoid/pulse waveform generator with its own period counter and IDLE/RISE/ON/FALL/LOW FSM.
// Settings are shadowed at IDLE exit and at each period wrap, so mid-period writes never glitch.
// Optional feature macro: FG_TRAP_INVERT_EN adds invert_i (out = amp - internal value).
// Ports: clk_i clock, rstn_i synchronous active-low reset, fg_if settings/output bundle (slave).
module fg_trapezoid_gen
  import fg_trapezoid_gen_pkg::*;
#(
  parameter int unsigned COUNTER_BITWIDTH  = 32,
  parameter int unsigned WAVEFORM_BITWIDTH = 16
) (
  input logic               clk_i,
  input logic               rstn_i,
  fg_trapezoid_gen_if.slave fg_if
);

  localparam int unsigned Cbw = COUNTER_BITWIDTH;
  localparam int unsigned Wbw = WAVEFORM_BITWIDTH;
  localparam logic [Cbw-1:0] CntOne = {{(Cbw-1){1'b0}}, 1'b1};

  fg_state_e      r_state, w_state_next;
  logic [Cbw-1:0] r_cnt, w_cnt_next;
  logic [Cbw-1:0] r_period, r_on_time;
  logic [Wbw-1:0] r_k_rise, r_k_fall, r_amp;
  logic [Wbw-1:0] r_val, w_val_next;
  logic [Wbw-1:0] r_out, w_out_next;
  logic [Wbw-1:0] w_sat_step, w_sat_res;
  logic           w_sat_sub, w_sat_reached;
  logic           w_load, w_at_on_end, w_at_wrap;
`ifdef FG_TRAP_INVERT_EN
  logic           r_invert;
`endif

  assign w_sat_sub   = (r_state == StFall);
  assign w_sat_step  = w_sat_sub ? r_k_fall : r_k_rise;
  // on_time==0 wraps to all-ones, which cnt never reaches inside a valid period.
  assign w_at_on_end = (r_cnt == r_on_time - CntOne);
  assign w_at_wrap   = (r_cnt == r_period - CntOne);

  fg_trapezoid_gen_sat_step #(
    .WIDTH (Wbw)
  ) u_sat_step (
    .i_val     (r_val),
    .i_step    (w_sat_step),
    .i_limit   (r_amp),
    .i_sub     (w_sat_sub),
    .o_res     (w_sat_res),
    .o_reached (w_sat_reached)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_val_next   = r_val;
    w_out_next   = r_out;
    w_load       = 1'b0;
    if (fg_if.clk_en_i) begin
      if (!fg_if.en_i) begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
        w_val_next   = '0;
      end else if (r_state == StIdle) begin
        w_val_next = '0;
        w_cnt_next = '0;
        if (fg_if.period_i != '0) begin
          w_load       = 1'b1;
          w_state_next = StRise;
        end
      end else begin
        // Value update always follows the current state; overrides only redirect the FSM.
        case (r_state)
          StRise: begin
            w_val_next = w_sat_res;
            if (w_sat_reached) w_state_next = StOn;
          end
          StOn:   w_val_next = r_amp;
          StFall: begin
            w_val_next = w_sat_res;
            if (w_sat_reached) w_state_next = StLow;
          end
          StLow:  w_val_next = '0;
          default: begin
            w_state_next = StIdle;
            w_val_next   = '0;
          end
        endcase
        if ((r_state == StRise || r_state == StOn) && w_at_on_end) w_state_next = StFall;
        if (w_at_wrap) begin
          w_cnt_next = '0;
          if (fg_if.period_i != '0) begin
            w_state_next = StRise;
            w_load       = 1'b1;
          end else begin
            w_state_next = StIdle;
            w_val_next   = '0;
          end
        end else begin
          w_cnt_next = r_cnt + CntOne;
        end
      end
      // Output is forced to 0 around IDLE, including the IDLE exit step.
      if (r_state == StIdle || w_state_next == StIdle) begin
        w_out_next = '0;
      end else begin
`ifdef FG_TRAP_INVERT_EN
        w_out_next = r_invert ? (r_amp - w_val_next) : w_val_next;
`else
        w_out_next = w_val_next;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_period  <= '0;
      r_on_time <= '0;
      r_k_rise  <= '0;
      r_k_fall  <= '0;
      r_amp     <= '0;
      r_val     <= '0;
      r_out     <= '0;
`ifdef FG_TRAP_INVERT_EN
      r_invert  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_val   <= w_val_next;
      r_out   <= w_out_next;
      if (w_load) begin
        r_period  <= fg_if.period_i;
        r_on_time <= fg_if.on_time_i;
        r_k_rise  <= fg_if.k_rise_i;
        r_k_fall  <= fg_if.k_fall_i;
        r_amp     <= fg_if.amplitude_i;
`ifdef FG_TRAP_INVERT_EN
        r_invert  <= fg_if.invert_i;
`endif
      end
    end
  end

  assign fg_if.out_o          = $signed({1'b0, r_out});
  assign fg_if.state_o        = r_state;
  assign fg_if.period_start_o = fg_if.clk_en_i && fg_if.en_i && (r_state != StIdle)
                                && (r_cnt == '0);

endmodule

// File: tb/tb_fg_trapezoid_gen.sv
// Self-checking bench for fg_trapezoid_gen: table of per-cycle vectors with hand-computed
// expected out_o/state_o (after the edge) and period_start_o (before the edge).
module tb_fg_trapezoid_gen;

  typedef struct {
    bit          rstn;
    bit          ce;
    bit          en;
    logic [31:0] per;
    logic [31:0] on;
    logic [15:0] kr;
    logic [15:0] kf;
    logic [15:0] amp;
    bit          inv;
    int          eo;
    int          es;
    bit          eps;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  logic [31:0] s_per, s_on;
  logic [15:0] s_kr, s_kf, s_amp;
  bit          s_inv;

  always #5 clk = ~clk;

  fg_trapezoid_gen_if #(
    .COUNTER_BITWIDTH  (32),
    .WAVEFORM_BITWIDTH (16)
  ) fg_if ();

  fg_trapezoid_gen #(
    .COUNTER_BITWIDTH  (32),
    .WAVEFORM_BITWIDTH (16)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .fg_if  (fg_if)
  );

  function automatic void add(bit r, bit ce, bit en, int eo, int es, bit eps);
    vec_t v;
    v.rstn = r;     v.ce = ce;     v.en = en;
    v.per  = s_per; v.on = s_on;   v.kr = s_kr;  v.kf = s_kf; v.amp = s_amp; v.inv = s_inv;
    v.eo   = eo;    v.es = es;     v.eps = eps;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // Watchdog: the run is a fixed number of cycles, this only guards against a stuck sim.
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    fg_if.clk_en_i = 1'b0;  fg_if.en_i = 1'b0;
    fg_if.period_i = '0;    fg_if.on_time_i = '0;
    fg_if.k_rise_i = '0;    fg_if.k_fall_i = '0;  fg_if.amplitude_i = '0;
`ifdef FG_TRAP_INVERT_EN
    fg_if.invert_i = 1'b0;
`endif

    // Test 1: basic trapezoid, period 10, on 6.
    s_per = 10; s_on = 6; s_kr = 100; s_kf = 50; s_amp = 250; s_inv = 0;
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 100, 1, 1);
    add(1, 1, 1, 200, 1, 0);
    add(1, 1, 1, 250, 2, 0);
    add(1, 1, 1, 250, 2, 0);
    add(1, 1, 1, 250, 2, 0);
    add(1, 1, 1, 250, 3, 0);
    add(1, 1, 1, 200, 3, 0);
    add(1, 1, 1, 150, 3, 0);
    add(1, 1, 1, 100, 3, 0);
    add(1, 1, 1, 50, 1, 0);
    add(1, 1, 1, 150, 1, 1);
    add(1, 1, 1, 250, 2, 0);

    // Test 2: steep fall reaches 0, LOW holds until the wrap.
    s_kf = 200;
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 100, 1, 1);
    add(1, 1, 1, 200, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 250, 2, 0);
    add(1, 1, 1, 250, 3, 0);
    add(1, 1, 1, 50, 3, 0);
    add(1, 1, 1, 0, 4, 0);
    add(1, 1, 1, 0, 4, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 100, 1, 1);

    // Test 3: amplitude change mid-period only applies from the next period.
    s_kf = 50;
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 100, 1, 1);
    add(1, 1, 1, 200, 1, 0);
    add(1, 1, 1, 250, 2, 0);
    s_amp = 400;
    add(1, 1, 1, 250, 2, 0);
    add(1, 1, 1, 250, 2, 0);
    add(1, 1, 1, 250, 3, 0);
    add(1, 1, 1, 200, 3, 0);
    add(1, 1, 1, 150, 3, 0);
    add(1, 1, 1, 100, 3, 0);
    add(1, 1, 1, 50, 1, 0);
    add(1, 1, 1, 150, 1, 1);
    add(1, 1, 1, 250, 1, 0);
    add(1, 1, 1, 350, 1, 0);
    add(1, 1, 1, 400, 2, 0);
    add(1, 1, 1, 400, 2, 0);

    // Test 4: on_time >= period never falls; next RISE saturates at once.
    s_amp = 250; s_on = 20;
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 100, 1, 1);
    add(1, 1, 1, 200, 1, 0);
    for (int i = 0; i < 7; i++) add(1, 1, 1, 250, 2, 0);
    add(1, 1, 1, 250, 1, 0);
    add(1, 1, 1, 250, 2, 1);

    // Test 5: en drop at cnt 4, then reset in the middle of RISE.
    s_on = 6;
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 100, 1, 1);
    add(1, 1, 1, 200, 1, 0);
    add(1, 1, 1, 250, 2, 0);
    add(1, 1, 1, 250, 2, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 100, 1, 1);
    add(0, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);

    // Test 6: clk_en gating holds every value on the off cycles.
    add(0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 0, 1, 0, 1, 0);
    add(1, 1, 1, 100, 1, 1);
    add(1, 0, 1, 100, 1, 0);
    add(1, 1, 1, 200, 1, 0);
    add(1, 0, 1, 200, 1, 0);
    add(1, 1, 1, 250, 2, 0);
    add(1, 0, 1, 250, 2, 0);

    // Boundaries: period 0 stays IDLE; amp 0 goes RISE->ON on the first step.
    s_per = 0;
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    s_per = 10; s_amp = 0;
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 0, 2, 1);
    add(1, 1, 1, 0, 2, 0);

`ifdef FG_TRAP_INVERT_EN
    // Inverted trapezoid: amp - internal value.
    s_amp = 250; s_inv = 1;
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 150, 1, 1);
    add(1, 1, 1, 50, 1, 0);
    add(1, 1, 1, 0, 2, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rstn                 = vecs[i].rstn;
      fg_if.clk_en_i       = vecs[i].ce;
      fg_if.en_i           = vecs[i].en;
      fg_if.period_i       = vecs[i].per;
      fg_if.on_time_i      = vecs[i].on;
      fg_if.k_rise_i       = vecs[i].kr;
      fg_if.k_fall_i       = vecs[i].kf;
      fg_if.amplitude_i    = vecs[i].amp;
`ifdef FG_TRAP_INVERT_EN
      fg_if.invert_i       = vecs[i].inv;
`endif
      #1;
      chk("period_start", i, int'(fg_if.period_start_o), int'(vecs[i].eps));
      @(posedge clk);
      #1;
      chk("out", i, int'(fg_if.out_o), vecs[i].eo);
      chk("state", i, int'(fg_if.state_o), vecs[i].es);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
